prog_mem: RTL and testbench
===========================

# prog_mem

Parametrised, writable program memory for the TD4 core, replacing the fixed 16-word instruction ROM. The CPU reads it combinationally by address, exactly like the ROM it replaces. A byte-stream loader port rewrites the whole image at run time and verifies it with a checksum word. The CPU is held while a load is in progress or after a failed load. Synchronous reset restores the built-in blink program.

## Interface
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
- DATA_W, 8, instruction word width.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- address  in  ADDR_W  CPU fetch address.
- dout  out  DATA_W  instruction at `address`; combinational read of the memory array.
- load_start  in  1  one-cycle pulse; begins (or restarts) a load.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  DATA_W  image word or checksum word.
- load_ready  out  1  loader accepts a word this cycle.
- load_busy  out  1  a load is in progress.
- load_done  out  1  one-cycle pulse: load finished with a good checksum.
- load_error  out  1  sticky flag: last load had a bad checksum.
- cpu_hold  out  1  CPU must not advance its PC or registers.

## Operation
- Array: DEPTH x DATA_W registers.
- Default image, written on reset:
  - word0 = 8'hBF (OUT 15), word1 = 8'hB0 (OUT 0), word2 = 8'hF0 (JMP 0).
  - All other words 0.
  - Values are zero-extended or truncated to DATA_W.
- FSM states: IDLE, LOAD, CHECK.
- IDLE:
  - load_ready = 0.
  - load_start -> LOAD; word counter wcnt = 0; running sum = 0; load_error cleared.
- LOAD:
  - load_ready = 1.
  - On load_valid: write load_data to mem[wcnt]; sum += load_data (mod 2**DATA_W); wcnt += 1.
  - After the write to address DEPTH-1 -> CHECK.
- CHECK:
  - load_ready = 1.
  - On load_valid: compare load_data with sum.
  - Equal: pulse load_done.
  - Not equal: set load_error.
  - Either way -> IDLE.
- load_start in LOAD or CHECK:
  - Restarts the load: wcnt = 0, sum = 0, state LOAD, load_error cleared.
  - Any load_valid in the same cycle is ignored; no write.
- load_valid in IDLE is ignored.
- Words already written by an aborted load stay in memory. No rollback; the default image is restored only by reset.
- load_busy = (state != IDLE).
- cpu_hold = load_busy | load_error.
- wcnt is ADDR_W+1 bits, so DEPTH itself is representable; the write address is wcnt[ADDR_W-1:0].

## Timing
- Reset values:
  - State IDLE, wcnt 0, sum 0.
  - load_ready 0, load_busy 0, load_done 0, load_error 0, cpu_hold 0.
  - Array holds the default image.
  - dout = default image at `address`.
- Reset has priority over every other input and takes effect at the next edge.
- Reset mid-load: the next edge returns to IDLE and rewrites the full default image.
- load_ready rises the cycle after the load_start edge. A load therefore takes at least DEPTH+2 cycles: 1 start, DEPTH data, 1 checksum.
- Data transfer occurs on any edge with load_valid & load_ready. load_valid may stall for any number of cycles.
- Memory write latency is one edge. dout for that address shows the new word in the cycle after the accepting edge.
- load_done is high for exactly the one cycle after the accepting CHECK edge.
- load_error rises in that same cycle and stays high until reset or the next load_start.
- cpu_hold rises the cycle after load_start. It falls the cycle after a good checksum is accepted.

## Test plan
- Reset image: assert reset for 1 cycle, then sweep address 0..15 -> dout = BF, B0, F0, then 00 for addresses 3..15; cpu_hold = 0.
- Good load (defaults): pulse load_start, send words 0x01..0x10 back-to-back, then checksum 0x88 -> load_done pulses once; load_error = 0; cpu_hold drops; dout[addr k] = k+1.
- Bad checksum: same data, checksum 0x87 -> load_error = 1 and stays high; cpu_hold stays 1; no load_done pulse; data stays written.
- Stalled stream: insert random gaps in load_valid, and present load_valid while in IDLE -> IDLE words are ignored; final memory and checksum result match the no-gap run.
- Restart and reset: load_start together with load_valid at word 5 -> that word is not written; wcnt restarts at 0. Assert reset at word 9 of a load -> next cycle the array equals the default image and all flags are 0.
- Parameter sweep ADDR_W = 3 and DATA_W = 12: good load of 8 words plus checksum -> load_done pulses; checksum computed mod 4096; reset image word0 = 12'h0BF.

Source files
------------

// File: rtl/prog_mem.sv
// Writable TD4 program memory: combinational fetch port plus byte-stream image loader with checksum.
// Latency: dout is combinational on address; a loader write shows on dout the cycle after it is accepted.
// Backpressure: load_ready is low in IDLE, high in LOAD/CHECK; load_valid may stall any number of cycles.
//
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset (restores blink image)
//   address / dout      - CPU fetch address and instruction word at that address
//   load_start          - pulse: begin or restart an image load
//   load_valid/_data    - loader word stream (DEPTH image words, then one checksum word)
//   load_ready          - loader word accepted when load_valid & load_ready
//   load_busy/done/error- status: load in progress / good-checksum pulse / sticky bad checksum
//   cpu_hold            - CPU must stall (load in progress or last load failed)
module prog_mem #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] dout,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_error,
    output logic              cpu_hold
);
    localparam int DEPTH = 2**ADDR_W;
    // wcnt value while the final image word is being written
    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(DEPTH-1);
    localparam logic [ADDR_W:0] WCNT_ONE  = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Built-in blink program: OUT 15, OUT 0, JMP 0; remaining words zero.
    function automatic logic [DATA_W-1:0] default_word(input int idx);
        case (idx)
            0:       return DATA_W'(8'hBF);
            1:       return DATA_W'(8'hB0);
            2:       return DATA_W'(8'hF0);
            default: return '0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        sum_d   = sum_q;
        done_d  = 1'b0;
        error_d = error_q;
        mem_d   = mem_q;

        if (load_start) begin
            // Restart from any state; a word presented in the same cycle is dropped.
            state_d = ST_LOAD;
            wcnt_d  = '0;
            sum_d   = '0;
            error_d = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (load_valid) begin
                        mem_d[wcnt_q[ADDR_W-1:0]] = load_data;
                        sum_d  = sum_q + load_data;
                        wcnt_d = wcnt_q + WCNT_ONE;
                        if (wcnt_q == LAST_WORD) begin
                            state_d = ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (load_valid) begin
                        if (load_data == sum_q) begin
                            done_d = 1'b1;
                        end else begin
                            error_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            sum_q   <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= default_word(i);
            end
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            sum_q   <= sum_d;
            done_q  <= done_d;
            error_q <= error_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign dout       = mem_q[address];
    assign load_ready = (state_q != ST_IDLE);
    assign load_busy  = (state_q != ST_IDLE);
    assign load_done  = done_q;
    assign load_error = error_q;
    assign cpu_hold   = load_busy | error_q;

endmodule

// File: tb/tb_prog_mem.sv
module tb_prog_mem;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance (ADDR_W=4, DATA_W=8)
    logic       reset;
    logic [3:0] address;
    logic [7:0] dout;
    logic       load_start, load_valid;
    logic [7:0] load_data;
    logic       load_ready, load_busy, load_done, load_error, cpu_hold;

    // Narrow-address, wide-word instance (ADDR_W=3, DATA_W=12)
    logic        b_reset;
    logic [2:0]  b_address;
    logic [11:0] b_dout;
    logic        b_load_start, b_load_valid;
    logic [11:0] b_load_data;
    logic        b_load_ready, b_load_busy, b_load_done, b_load_error, b_cpu_hold;

    prog_mem dut (
        .clk(clk), .reset(reset), .address(address), .dout(dout),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .load_busy(load_busy), .load_done(load_done),
        .load_error(load_error), .cpu_hold(cpu_hold)
    );

    prog_mem #(.ADDR_W(3), .DATA_W(12)) dut_b (
        .clk(clk), .reset(b_reset), .address(b_address), .dout(b_dout),
        .load_start(b_load_start), .load_valid(b_load_valid), .load_data(b_load_data),
        .load_ready(b_load_ready), .load_busy(b_load_busy), .load_done(b_load_done),
        .load_error(b_load_error), .cpu_hold(b_cpu_hold)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference contents of each memory, maintained per accepted word
    logic [7:0]  ref_mem [16];
    logic [11:0] b_ref   [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ref_default();
        for (int a = 0; a < 16; a++) ref_mem[a] = 8'h00;
        ref_mem[0] = 8'hBF; ref_mem[1] = 8'hB0; ref_mem[2] = 8'hF0;
        for (int a = 0; a < 8; a++) b_ref[a] = 12'h000;
        b_ref[0] = 12'h0BF; b_ref[1] = 12'h0B0; b_ref[2] = 12'h0F0;
    endtask

    task automatic check_image(input string tag);
        for (int a = 0; a < 16; a++) begin
            address = 4'(a);
            @(negedge clk);
            chk($sformatf("%s_dout[%0d]", tag, a), {24'h0, dout}, {24'h0, ref_mem[a]});
        end
    endtask

    task automatic check_flags_idle(input string tag);
        chk({tag, "_ready"}, load_ready, 0);
        chk({tag, "_busy"},  load_busy,  0);
        chk({tag, "_done"},  load_done,  0);
        chk({tag, "_error"}, load_error, 0);
        chk({tag, "_hold"},  cpu_hold,   0);
    endtask

    // Stream a full image plus checksum; gap_pct is the chance of an idle cycle.
    task automatic run_load(input string tag, input logic [7:0] d [16], input logic [7:0] cks,
                            input int gap_pct, input bit do_start);
        logic [7:0] sum;
        int i;
        int budget;
        bit good;
        sum = 8'h00;
        for (int k = 0; k < 16; k++) sum = sum + d[k];
        good = (cks == sum);
        if (do_start) begin
            load_start = 1'b1;
            load_valid = 1'b0;
            chk({tag, "_ready_pre"}, load_ready, 0);
            tick();
            load_start = 1'b0;
            chk({tag, "_ready_start"}, load_ready, 1);
            chk({tag, "_busy_start"},  load_busy,  1);
            chk({tag, "_hold_start"},  cpu_hold,   1);
            chk({tag, "_errclr"},      load_error, 0);
        end
        i = 0;
        budget = 0;
        while (i <= 16 && budget < 2000) begin
            budget++;
            if (int'($urandom_range(99)) < gap_pct) begin
                load_valid = 1'b0;
                load_data  = 8'($urandom);
            end else begin
                load_valid = 1'b1;
                load_data  = (i < 16) ? d[i] : cks;
            end
            tick();
            if (load_valid) begin
                if (i < 16) ref_mem[i] = d[i];
                i++;
            end
            if (i <= 16) begin
                chk({tag, "_mid_done"}, load_done, 0);
                chk({tag, "_mid_busy"}, load_busy, 1);
            end
        end
        load_valid = 1'b0;
        chk({tag, "_words_accepted"}, i, 17);
        chk({tag, "_done"},  load_done,  good);
        chk({tag, "_error"}, load_error, !good);
        chk({tag, "_busy"},  load_busy,  0);
        chk({tag, "_hold"},  cpu_hold,   !good);
        tick();
        chk({tag, "_done_gone"},    load_done,  0);
        chk({tag, "_error_sticky"}, load_error, !good);
        chk({tag, "_hold_sticky"},  cpu_hold,   !good);
    endtask

    initial begin
        logic [7:0]  d [16];
        logic [7:0]  rsum;
        logic [11:0] bd [8];
        logic [11:0] bsum;

        reset = 1'b1; address = '0; load_start = 1'b0; load_valid = 1'b0; load_data = '0;
        b_reset = 1'b1; b_address = '0; b_load_start = 1'b0; b_load_valid = 1'b0; b_load_data = '0;
        ref_default();
        tick();
        reset = 1'b0;
        b_reset = 1'b0;

        // Reset state and default image
        check_flags_idle("rst");
        check_image("rst_img");

        // Good load with the documented image 1..16, checksum 0x88
        for (int k = 0; k < 16; k++) d[k] = 8'(k + 1);
        run_load("good", d, 8'h88, 0, 1'b1);
        check_image("good_img");

        // Bad checksum: error sticks, CPU stays held, data still written
        run_load("bad", d, 8'h87, 0, 1'b1);
        repeat (3) tick();
        chk("bad_error_hold3", load_error, 1);
        chk("bad_cpu_hold3",   cpu_hold,   1);
        check_image("bad_img");

        // Random image, no gaps, then same image with gaps and IDLE junk
        for (int k = 0; k < 16; k++) d[k] = 8'($urandom);
        rsum = 8'h00;
        for (int k = 0; k < 16; k++) rsum = rsum + d[k];
        run_load("rnd", d, rsum, 0, 1'b1);
        check_image("rnd_img");
        for (int c = 0; c < 3; c++) begin
            load_valid = 1'b1;
            load_data  = 8'($urandom);
            tick();
            chk("idle_junk_ready", load_ready, 0);
        end
        load_valid = 1'b0;
        check_image("idle_junk_img");
        run_load("stall", d, rsum, 40, 1'b1);
        check_image("stall_img");

        // Restart with load_valid at word 5: that word is dropped, count restarts
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            load_valid = 1'b1;
            load_data  = 8'(8'hA0 + k);
            tick();
            ref_mem[k] = 8'(8'hA0 + k);
        end
        load_start = 1'b1; load_valid = 1'b1; load_data = 8'hEE;
        tick();
        load_start = 1'b0; load_valid = 1'b0;
        chk("restart_busy", load_busy, 1);
        address = 4'd5; #1;
        chk("restart_word5_kept", dout, ref_mem[5]);
        address = 4'd4; #1;
        chk("restart_word4_aborted", dout, 8'hA4);
        for (int k = 0; k < 16; k++) d[k] = 8'(8'h30 + 3 * k);
        rsum = 8'h00;
        for (int k = 0; k < 16; k++) rsum = rsum + d[k];
        run_load("restart", d, rsum, 20, 1'b0);
        check_image("restart_img");

        // Reset at word 9 of a load restores the default image and clears flags
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            load_valid = 1'b1;
            load_data  = 8'($urandom);
            tick();
        end
        reset = 1'b1; load_valid = 1'b1; load_data = 8'h55;
        tick();
        reset = 1'b0; load_valid = 1'b0;
        ref_default();
        check_flags_idle("midrst");
        check_image("midrst_img");

        // Wide instance: reset image and good load with checksum mod 4096
        for (int a = 0; a < 8; a++) begin
            b_address = 3'(a);
            @(negedge clk);
            chk($sformatf("b_rst_dout[%0d]", a), {20'h0, b_dout}, {20'h0, b_ref[a]});
        end
        chk("b_rst_hold", b_cpu_hold, 0);
        for (int k = 0; k < 8; k++) bd[k] = 12'(12'h800 + $urandom_range(12'h7FF));
        bsum = 12'h000;
        for (int k = 0; k < 8; k++) bsum = 12'((int'(bsum) + int'(bd[k])) % 4096);
        b_load_start = 1'b1; tick(); b_load_start = 1'b0;
        chk("b_ready_start", b_load_ready, 1);
        for (int k = 0; k <= 8; k++) begin
            b_load_valid = 1'b1;
            b_load_data  = (k < 8) ? bd[k] : bsum;
            tick();
            if (k < 8) b_ref[k] = bd[k];
        end
        b_load_valid = 1'b0;
        chk("b_done",  b_load_done,  1);
        chk("b_error", b_load_error, 0);
        chk("b_hold",  b_cpu_hold,   0);
        tick();
        chk("b_done_gone", b_load_done, 0);
        for (int a = 0; a < 8; a++) begin
            b_address = 3'(a);
            @(negedge clk);
            chk($sformatf("b_load_dout[%0d]", a), {20'h0, b_dout}, {20'h0, b_ref[a]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
